// File: rtl/sdram_rv_arbiter_pkg.sv
// sdram_rv_arbiter_pkg: shared state encoding, widths and round-robin picker
package sdram_rv_arbiter_pkg;
  localparam int ARB_ADDR_W = 22;
  localparam int ARB_MAX_REQ = 8;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t WAIT = 2'd1;
  localparam arb_state_t DATA = 2'd2;
  // First pending index after ptr, wrapping modulo nreq; 0 when nothing pending
  function automatic int rr_pick(input logic [ARB_MAX_REQ-1:0] pending, input int ptr, input int nreq);
    int pick;
    pick = 0;
    for (int k = nreq; k >= 1; k--)
      if (pending[(ptr + k) % nreq]) pick = (ptr + k) % nreq;
    return pick;
  endfunction
endpackage

// File: rtl/sdram_rv_arbiter_picker.sv
// arb_rr_picker: pending/priority-mask/pointer to grant index and valid
module arb_rr_picker
  import sdram_rv_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW = 2,
  parameter logic [NREQ-1:0] PRIO_MASK = 3'b001
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            valid,
  output logic            prio
);
  logic [NREQ-1:0] masked;
  always_comb begin
    masked = pending & PRIO_MASK;
    valid = |pending;
    prio = |masked;
    grant = IW'(rr_pick(ARB_MAX_REQ'(pending), int'(ptr), NREQ));
    for (int i = NREQ - 1; i >= 0; i--)
      if (masked[i]) grant = IW'(i);
  end
endmodule

// File: rtl/sdram_rv_arbiter.sv
// sdram_rv_arbiter: shares one toggle-handshake SDRAM port between NREQ requesters
module sdram_rv_arbiter
  import sdram_rv_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter logic [NREQ-1:0] PRIO_MASK = 3'b001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        req_ack,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*2-1:0]      req_ds,
  input  logic [NREQ*16-1:0]     req_din,
  output logic [15:0]            req_dout,
  output logic [NREQ-1:0]        req_last,
  output logic                   mem_req,
  input  logic                   mem_req_ack,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [1:0]             mem_ds,
  output logic [15:0]            mem_din,
  input  logic [15:0]            mem_dout,
  output logic                   busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  arb_state_t state;
  logic [IW-1:0] g, ptr, pick;
  logic valid, prio;
  arb_rr_picker #(.NREQ(NREQ), .IW(IW), .PRIO_MASK(PRIO_MASK)) u_pick (
    .pending(req ^ req_ack),
    .ptr(ptr),
    .grant(pick),
    .valid(valid),
    .prio(prio)
  );
  assign busy = state != IDLE;
  // Grants wait for mem_req == mem_req_ack so a reset mid-access cannot overlap the stale one
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      g <= '0;
      ptr <= IW'(NREQ - 1);
      req_ack <= '0;
      req_dout <= '0;
      req_last <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_ds <= '0;
      mem_din <= '0;
    end else
      case (state)
        IDLE: if (valid && mem_req == mem_req_ack) begin
          mem_addr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_we <= req_we[pick];
          mem_ds <= req_ds[int'(pick)*2 +: 2];
          mem_din <= req_din[int'(pick)*16 +: 16];
          mem_req <= ~mem_req;
          g <= pick;
          if (!prio) ptr <= pick;
          state <= WAIT;
        end
        WAIT: if (mem_req == mem_req_ack) begin
          if (mem_we) begin
            req_ack[g] <= ~req_ack[g];
            req_last <= NREQ'(1) << g;
            state <= IDLE;
          end else state <= DATA;
        end
        DATA: begin
          req_dout <= mem_dout;
          req_ack[g] <= ~req_ack[g];
          req_last <= NREQ'(1) << g;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sdram_rv_arbiter.sv
// tb_sdram_rv_arbiter: randomized scoreboard bench with SDRAM and arbitration reference models
module tb_sdram_rv_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 22;
  localparam logic [2:0] PRIO = 3'b001;
  typedef struct packed {logic [AW-1:0] a; logic w; logic [1:0] d; logic [15:0] x;} rq_t;
  logic clk = 0, reset = 1;
  logic [NREQ-1:0] req, req_ack, req_we, req_last;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0] req_ds;
  logic [NREQ*16-1:0] req_din;
  logic [15:0] req_dout, mem_din, mem_dout;
  logic mem_req, mem_req_ack, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0] mem_ds;
  always #5 clk = ~clk;
  sdram_rv_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .PRIO_MASK(PRIO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ack(req_ack), .req_addr(req_addr),
    .req_we(req_we), .req_ds(req_ds), .req_din(req_din), .req_dout(req_dout),
    .req_last(req_last), .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );
  int checks = 0, fails = 0, dly_fixed = 0, sd_cnt = -1;
  rq_t q[NREQ][$];
  logic [15:0] ref_mem [logic [AW-1:0]];
  logic [15:0] sd_mem [logic [AW-1:0]];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[21:16], 10'h2A5};
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] d, input logic [15:0] x);
    return {d[1] ? x[15:8] : old[15:8], d[0] ? x[7:0] : old[7:0]};
  endfunction
  function automatic int pick(input logic [2:0] p, input int ptr, output bit by_prio);
    by_prio = 0;
    for (int i = 0; i < NREQ; i++) if (p[i] && PRIO[i]) begin by_prio = 1; return i; end
    for (int k = 1; k <= NREQ; k++) if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction
  // SDRAM model: acks after a delay, keeps its own memory from the DUT's mem_* outputs
  initial begin
    mem_req_ack = 0;
    mem_dout = 0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin mem_req_ack = 0; sd_cnt = -1; end
      else if (mem_req != mem_req_ack) begin
        if (sd_cnt < 0) sd_cnt = dly_fixed > 0 ? dly_fixed : int'($urandom_range(0, 3));
        if (sd_cnt == 0) begin
          if (mem_we) sd_mem[mem_addr] = merge(sd_mem.exists(mem_addr) ? sd_mem[mem_addr] : init_word(mem_addr), mem_ds, mem_din);
          else mem_dout = sd_mem.exists(mem_addr) ? sd_mem[mem_addr] : init_word(mem_addr);
          mem_req_ack = mem_req;
          sd_cnt = -1;
        end else sd_cnt--;
      end
    end
  end
  // Monitor: predicts the winner of each grant and the ack timing, pops the scoreboard
  logic [2:0] exp_ack = 0, pend_prev = 0;
  logic prev_mreq = 0, prev_mack = 0;
  bit active = 0, due, bp;
  int ptr_m = NREQ - 1, cnt = 0, g_m = 0, w;
  rq_t cur;
  logic [15:0] exp_data;
  always @(negedge clk) begin
    if (reset) begin
      exp_ack = 0; pend_prev = 0; prev_mreq = 0; prev_mack = 0;
      active = 0; cnt = 0; ptr_m = NREQ - 1;
      for (int i = 0; i < NREQ; i++) q[i].delete();
    end else begin
      due = 0;
      if (mem_req != prev_mreq) begin
        w = pick(pend_prev, ptr_m, bp);
        if (pend_prev == 0 || active || q[w].size() == 0) begin
          checks++; fails++;
          $display("FAIL grant: unexpected grant pending=%b active=%0d winner=%0d at %0t", pend_prev, active, w, $time);
        end else begin
          cur = q[w].pop_front();
          g_m = w; active = 1; cnt = 0;
          if (!bp) ptr_m = w;
          chk("mem_addr", 32'(mem_addr), 32'(cur.a));
          chk("mem_we", 32'(mem_we), 32'(cur.w));
          chk("mem_ds", 32'(mem_ds), 32'(cur.d));
          chk("mem_din", 32'(mem_din), 32'(cur.x));
          if (cur.w) ref_mem[cur.a] = merge(ref_mem.exists(cur.a) ? ref_mem[cur.a] : init_word(cur.a), cur.d, cur.x);
          else exp_data = ref_mem.exists(cur.a) ? ref_mem[cur.a] : init_word(cur.a);
        end
      end
      if (cnt > 0) begin cnt--; due = cnt == 0; end
      else if (active && mem_req_ack != prev_mack) cnt = cur.w ? 1 : 2;
      if (due) begin
        exp_ack[g_m] = ~exp_ack[g_m];
        active = 0;
        chk("req_last", 32'(req_last), 32'(3'b001 << g_m));
        if (!cur.w) chk("req_dout", 32'(req_dout), 32'(exp_data));
      end
      chk("req_ack", 32'(req_ack), 32'(exp_ack));
      chk("busy", 32'(busy), 32'(active));
      pend_prev = req ^ exp_ack;
      prev_mreq = mem_req;
      prev_mack = mem_req_ack;
    end
  end
  task automatic issue(input int i, input logic [AW-1:0] a, input logic we, input logic [1:0] d, input logic [15:0] x);
    req_addr[i*AW +: AW] = a;
    req_we[i] = we;
    req_ds[i*2 +: 2] = d;
    req_din[i*16 +: 16] = x;
    req[i] = ~req[i];
    q[i].push_back('{a: a, w: we, d: d, x: x});
  endtask
  task automatic wait_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && !active) return;
    end
    checks++; fails++;
    $display("FAIL wait_idle: timeout after %0d cycles", n);
  endtask
  task automatic wait_busy(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (busy) return;
    end
    checks++; fails++;
    $display("FAIL wait_busy: timeout after %0d cycles", n);
  endtask
  initial begin
    req = 0; req_addr = 0; req_we = 0; req_ds = 0; req_din = 0;
    ref_mem[22'h066000] = 16'hBEEF;
    sd_mem[22'h066000] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we_ds_din", {13'd0, mem_we, mem_ds, mem_din}, 0);
    chk("rst_dout_last", {13'd0, req_last, req_dout}, 0);
    chk("rst_busy", 32'(busy), 0);
    dly_fixed = 3;
    @(posedge clk); #1;
    issue(0, 22'h066000, 1'b0, 2'b11, 16'h0000);
    wait_idle(100);
    chk("rd_mem_addr", 32'(mem_addr), 32'h066000);
    chk("rd_mem_ds", 32'(mem_ds), 32'd3);
    chk("rd_dout", 32'(req_dout), 32'hBEEF);
    chk("rd_last", 32'(req_last), 32'b001);
    issue(1, 22'h000123, 1'b1, 2'b01, 16'h00A5);
    wait_idle(100);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_ds", 32'(mem_ds), 32'b01);
    chk("wr_mem_din", 32'(mem_din), 32'h00A5);
    chk("wr_last", 32'(req_last), 32'b010);
    issue(2, 22'h000123, 1'b0, 2'b11, 16'h0000);
    wait_idle(100);
    chk("wr_merge", 32'(req_dout), {16'd0, init_word(22'h000123) & 16'hFF00 | 16'h00A5});
    dly_fixed = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++)
          if (req[i] == req_ack[i] &&
              $urandom_range(0, 99) < (ph == 0 ? (i == 0 ? 0 : 50) : ph == 1 ? 30 : (i == 0 ? 95 : 60)))
            issue(i, 22'h066000 | AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 16'($urandom));
      end
      wait_idle(2000);
    end
    dly_fixed = 6;
    issue(2, 22'h066001, 1'b0, 2'b11, 16'h0000);
    wait_busy(20);
    req[1] = ~req[1];
    @(posedge clk); #1;
    req[1] = ~req[1];
    wait_idle(100);
    chk("cancel_ack", 32'(req_ack[1]), 32'(req[1]));
    dly_fixed = 10;
    issue(0, 22'h066002, 1'b0, 2'b11, 16'h0000);
    wait_busy(20);
    @(posedge clk); #1;
    reset = 1;
    req = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_req_ack", 32'(req_ack), 0);
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_mem_ack", 32'(mem_req_ack), 0);
    chk("midrst_busy", 32'(busy), 0);
    dly_fixed = 0;
    @(posedge clk); #1;
    issue(2, 22'h066003, 1'b0, 2'b11, 16'h0000);
    wait_idle(100);
    chk("post_rst_ack", 32'(req_ack), 32'b100);
    chk("post_rst_last", 32'(req_last), 32'b100);
    for (int i = 0; i < NREQ; i++) chk("queue_empty", 32'(q[i].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
